ldpc_err_mon: RTL
=================

Name: ldpc_err_mon

Overview:
Receive-side monitor on the decoder output. It captures the decoded hard-decision vector `res` on each rising edge of the core's `term`, and XORs it against the expected codeword `ref` (all-zero in the current noise bench). It then popcounts the XOR vector SEG_W bits per cycle and maintains saturating BER/FER statistics; `errs` feeds the top-level error output.

Parameters:
DIM, 2304, codeword length in bits (R*D); must be a multiple of SEG_W
SEG_W, 64, bits popcounted per scan cycle; NSEG = DIM/SEG_W (36 at defaults)
CNT_W, 12, width of cumulative bit-error counter `errs`
FRM_W, 16, width of frame and frame-error counters
MAX_FRAMES, 1000, frame count at which `done` asserts and capture stops
FE_W, $clog2(DIM+1) (12), width of per-frame error count

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
term  in  1  decoder termination level; held high until decoder reset
res  in  DIM  decoded bits; valid while term high
ref  in  DIM  expected codeword; sampled with res
clr  in  1  synchronous clear of statistics
busy  out  1  frame capture/scan in progress
frame_done  out  1  one-cycle pulse: statistics updated for one frame
frame_errs  out  FE_W  bit errors in the last completed frame
errs  out  CNT_W  cumulative bit errors, saturating
frame_err_cnt  out  FRM_W  frames with frame_errs!=0, saturating
frame_cnt  out  FRM_W  frames completed
overrun  out  1  sticky: a term rising edge arrived while busy
done  out  1  sticky: frame_cnt == MAX_FRAMES

Behaviour:
- Reset (async): all outputs 0. State IDLE, internal accumulator 0, term_q = 1. term must therefore be seen low before the first capture.
- Capture event: term=1 && term_q=0 at a clock edge; term_q <= term every cycle. A level held high captures once.
- FSM states: IDLE, SCAN, UPD.
- IDLE: on a capture event with !done and !clr:
  - latch x = res ^ ref;
  - clear accumulator and seg index;
  - busy <= 1; go to SCAN.
- SCAN: each cycle, acc += popcount(x[seg*SEG_W +: SEG_W]) and seg++. After seg = NSEG-1 is processed, go to UPD. Occupies exactly NSEG cycles.
- UPD (one cycle):
  - frame_errs <= acc;
  - errs <= min(errs + acc, 2^CNT_W-1);
  - frame_err_cnt += (acc != 0), saturating;
  - frame_cnt += 1;
  - frame_done <= 1, busy <= 0;
  - done <= 1 if the new frame_cnt == MAX_FRAMES;
  - go to IDLE.
- Latency: frame_done is high in the cycle following edge k+NSEG+1, where k is the capture edge (37 edges at defaults). frame_done deasserts on the next edge.
- Capture event while busy (SCAN or UPD, incl. the UPD edge itself): frame dropped, overrun <= 1, scan in progress unaffected.
- Capture event while done: ignored; no overrun.
- frame_cnt never exceeds MAX_FRAMES; FRM_W counters otherwise saturate at all-ones.
- clr (synchronous, highest priority over capture and UPD):
  - zero all statistics, frame_errs, overrun and done;
  - abort any scan to IDLE; busy <= 0; no frame_done;
  - term_q still updates.
- Async rst mid-scan: immediate return to reset values; the partial frame is discarded.
- x and acc are internal; acc width FE_W never overflows (max DIM).

Test Plan:
1. res=ref=0, term 0→1 at edge k → frame_done high after edge k+37; frame_errs=0, errs=0, frame_cnt=1, frame_err_cnt=0, busy high edges k+1..k+36.
2. ref=0, res bits 0,63,64,2303 set → frame_errs=4, errs=4, frame_err_cnt=1; second identical frame → errs=8, frame_cnt=2.
3. res=all-ones, ref=0, two frames → after first, errs=2304; after second, errs=4095 (saturated), frame_errs=2304, frame_err_cnt=2.
4. term pulsed low then high 10 cycles after a capture → overrun=1, exactly one frame_done, frame_cnt=1. term held high 100 cycles → single capture.
5. MAX_FRAMES=3, four frames → done=1 after the third frame_done, fourth ignored, frame_cnt=3, overrun=0; then clr → all counters 0, done=0, next frame counted as frame_cnt=1.
6. rst asserted 20 cycles into SCAN → outputs 0 immediately, no frame_done. term low then high after release → normal frame, frame_cnt=1.

Source files
------------

// File: rtl/ldpc_err_mon_if.sv
// rtl/ldpc_err_mon_if.sv - capture/statistics bundle between decoder side and error monitor
//   master: drives term, res, ref_cw, clr; observes the statistics
//   slave : the monitor; samples term/res/ref_cw/clr, drives busy, frame_done,
//           frame_errs, errs, frame_err_cnt, frame_cnt, overrun, done
interface ldpc_err_mon_if #(
  parameter int DIM   = 2304,
  parameter int CNT_W = 12,
  parameter int FRM_W = 16,
  parameter int FE_W  = $clog2(DIM + 1)
);
  logic             term;
  logic [DIM-1:0]   res;
  logic [DIM-1:0]   ref_cw;
  logic             clr;
  logic             busy;
  logic             frame_done;
  logic [FE_W-1:0]  frame_errs;
  logic [CNT_W-1:0] errs;
  logic [FRM_W-1:0] frame_err_cnt;
  logic [FRM_W-1:0] frame_cnt;
  logic             overrun;
  logic             done;

  modport master (
    output term, res, ref_cw, clr,
    input  busy, frame_done, frame_errs, errs, frame_err_cnt, frame_cnt, overrun, done
  );

  modport slave (
    input  term, res, ref_cw, clr,
    output busy, frame_done, frame_errs, errs, frame_err_cnt, frame_cnt, overrun, done
  );
endinterface

// File: rtl/ldpc_err_mon.sv
// rtl/ldpc_err_mon.sv - decoder-output bit/frame error monitor with saturating statistics
//   clk, rst (async, active-high)
//   mon.term/res/ref_cw : capture on term rising edge, x = res ^ ref_cw
//   mon.clr             : synchronous clear of statistics, aborts a scan
//   mon.busy/frame_done/frame_errs/errs/frame_err_cnt/frame_cnt/overrun/done : status
module ldpc_err_mon #(
  parameter int DIM        = 2304,
  parameter int SEG_W      = 64,
  parameter int CNT_W      = 12,
  parameter int FRM_W      = 16,
  parameter int MAX_FRAMES = 1000,
  parameter int FE_W       = $clog2(DIM + 1)
) (
  input logic           clk,
  input logic           rst,
  ldpc_err_mon_if.slave mon
);
  localparam int NSEG   = DIM / SEG_W;
  localparam int SEG_IW = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int SUM_W  = ((CNT_W > FE_W) ? CNT_W : FE_W) + 1;

  localparam logic [SEG_IW-1:0] SEG_LAST  = SEG_IW'(NSEG - 1);
  localparam logic [FRM_W-1:0]  FRM_MAX   = '1;
  localparam logic [FRM_W-1:0]  FRM_LIMIT = FRM_W'(MAX_FRAMES);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, SCAN, UPD} state_t;

  state_t           state, state_nxt;
  logic             term_q;
  logic             cap;
  logic [DIM-1:0]   x;
  logic [FE_W-1:0]  acc;
  logic [SEG_IW-1:0] seg;
  logic             frame_done;
  logic [FE_W-1:0]  frame_errs;
  logic [CNT_W-1:0] errs;
  logic [FRM_W-1:0] frame_err_cnt;
  logic [FRM_W-1:0] frame_cnt;
  logic             overrun;
  logic             done;
  logic [SUM_W-1:0] errs_sum;
  logic [FRM_W-1:0] frame_cnt_nxt;

  function automatic logic [FE_W-1:0] popcnt(input logic [SEG_W-1:0] v);
    logic [FE_W-1:0] c;
    c = '0;
    for (int i = 0; i < SEG_W; i++) c = c + FE_W'(v[i]);
    return c;
  endfunction

  // term_q resets high so a level already high at reset release is not a capture.
  assign cap = mon.term & ~term_q;

  assign errs_sum      = SUM_W'(errs) + SUM_W'(acc);
  assign frame_cnt_nxt = (frame_cnt != FRM_MAX) ? frame_cnt + 1'b1 : frame_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cap && !done) state_nxt = SCAN;
      SCAN:    if (seg == SEG_LAST) state_nxt = UPD;
      UPD:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (mon.clr) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      term_q        <= 1'b1;
      x             <= '0;
      acc           <= '0;
      seg           <= '0;
      frame_done    <= 1'b0;
      frame_errs    <= '0;
      errs          <= '0;
      frame_err_cnt <= '0;
      frame_cnt     <= '0;
      overrun       <= 1'b0;
      done          <= 1'b0;
    end else begin
      term_q     <= mon.term;
      frame_done <= 1'b0;
      if (mon.clr) begin
        acc           <= '0;
        seg           <= '0;
        frame_errs    <= '0;
        errs          <= '0;
        frame_err_cnt <= '0;
        frame_cnt     <= '0;
        overrun       <= 1'b0;
        done          <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cap && !done) begin
              x   <= mon.res ^ mon.ref_cw;
              acc <= '0;
              seg <= '0;
            end
          end
          SCAN: begin
            // Shift the error vector down so the live segment is always the LSBs.
            acc <= acc + popcnt(x[SEG_W-1:0]);
            x   <= x >> SEG_W;
            seg <= seg + 1'b1;
          end
          UPD: begin
            frame_errs <= acc;
            errs       <= (errs_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : errs_sum[CNT_W-1:0];
            if (acc != '0 && frame_err_cnt != FRM_MAX) frame_err_cnt <= frame_err_cnt + 1'b1;
            frame_cnt  <= frame_cnt_nxt;
            frame_done <= 1'b1;
            if (frame_cnt_nxt == FRM_LIMIT) done <= 1'b1;
          end
          default: ;
        endcase
        // A new frame arriving while one is still being scanned or committed is lost.
        if (cap && state != IDLE && !done) overrun <= 1'b1;
      end
    end
  end

  assign mon.busy          = (state != IDLE);
  assign mon.frame_done    = frame_done;
  assign mon.frame_errs    = frame_errs;
  assign mon.errs          = errs;
  assign mon.frame_err_cnt = frame_err_cnt;
  assign mon.frame_cnt     = frame_cnt;
  assign mon.overrun       = overrun;
  assign mon.done          = done;
endmodule
